// File: rtl/mb32_to_mb8_bridge_if.sv
// mb32_to_mb8_bridge_if: word-request side and mb8 byte-bus side of the 32-to-8 bridge
interface mb32_to_mb8_bridge_if #(
    parameter int ASZ = 17,
    parameter int WSZ = ASZ - 2
);
    logic           req;
    logic           wr;
    logic [WSZ-1:0] waddr;
    logic [31:0]    wdata;
    logic [3:0]     be;
    logic           rdy;
    logic           done;
    logic [31:0]    rdata;
    logic [ASZ-1:0] ai;
    logic           we;
    logic [7:0]     vi;
    logic [7:0]     vo;
    modport slave (
        input  req, wr, waddr, wdata, be, vo,
        output rdy, done, rdata, ai, we, vi
    );
    modport master (
        output req, wr, waddr, wdata, be, vo,
        input  rdy, done, rdata, ai, we, vi
    );
endinterface

// File: rtl/mb32_to_mb8_bridge.sv
// mb32_to_mb8_bridge: splits 32-bit word requests into four little-endian mb8 byte accesses
module mb32_to_mb8_bridge #(
    parameter int ASZ = 17,
    parameter int WSZ = ASZ - 2
) (
    input logic clk,
    input logic rst,
    mb32_to_mb8_bridge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [WSZ-1:0] waddr_q, waddr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    rbuf_q, rbuf_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [ASZ-1:0] ai_q, ai_d;
    logic           we_q, we_d;
    logic [7:0]     vi_q, vi_d;
    logic [1:0]     nb;
    logic [1:0]     pb;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        ai_d    = ai_q;
        we_d    = 1'b0;
        vi_d    = vi_q;
        nb      = cnt_q[1:0] + 2'd1;
        pb      = cnt_q[1:0] - 2'd1;
        case (state_q)
            IDLE: if (bus.req) begin
                state_d = bus.wr ? WR : RD;
                cnt_d   = 3'd0;
                waddr_d = bus.waddr;
                wdata_d = bus.wdata;
                be_d    = bus.be;
                ai_d    = {bus.waddr, 2'd0};
                we_d    = bus.wr & bus.be[0];
                vi_d    = bus.wr ? bus.wdata[7:0] : vi_q;
            end
            WR: if (cnt_q == 3'd3) begin
                state_d = DONE;
            end else begin
                cnt_d = cnt_q + 3'd1;
                ai_d  = {waddr_q, nb};
                we_d  = be_q[nb];
                vi_d  = wdata_q[{nb, 3'b000} +: 8];
            end
            RD: begin
                // vo lags the address by one cycle, so cycle n captures byte n-1
                cnt_d = cnt_q + 3'd1;
                if (cnt_q < 3'd3) ai_d = {waddr_q, nb};
                if (cnt_q != 3'd0) rbuf_d[{pb, 3'b000} +: 8] = bus.vo;
                if (cnt_q == 3'd4) begin
                    state_d = DONE;
                    rdata_d = {bus.vo, rbuf_q[23:0]};
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            waddr_q <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            ai_q    <= '0;
            we_q    <= 1'b0;
            vi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            ai_q    <= ai_d;
            we_q    <= we_d;
            vi_q    <= vi_d;
        end
    end
    assign bus.rdy   = (state_q == IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.rdata = rdata_q;
    assign bus.ai    = ai_q;
    assign bus.we    = we_q;
    assign bus.vi    = vi_q;
endmodule

// File: doc/mb32_to_mb8_bridge.md
# mb32_to_mb8_bridge

Master-side bridge that turns single 32-bit word requests into four sequential byte accesses on the 8-bit single-port memory bus (mb8 protocol, 128K × 8 SPRAM behind it). It sits between a 32-bit initiator (eForth VM core or test driver) and the `spram8_128k` slave, owning address generation, write strobes and read-data reassembly. Byte order is little-endian: byte *n* of a word lives at byte address `{waddr, n[1:0]}`.

## Interface

- `ASZ`, 17: byte address width on the mb8 side (128K).
- `WSZ`, `ASZ-2` (15): word address width on the request side.

- `clk`  in  1  single system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  1  request valid; accepted on an edge where `req & rdy`.
- `wr`  in  1  1 = write, 0 = read; sampled at accept.
- `waddr`  in  WSZ  word address; sampled at accept.
- `wdata`  in  32  write data; sampled at accept.
- `be`  in  4  byte enables for writes (bit n ↔ byte n); ignored on reads.
- `rdy`  out  1  bridge idle, can accept.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  assembled read word; valid while `done`=1, held until next read completes.
- `ai`  out  ASZ  mb8 byte address to memory.
- `we`  out  1  mb8 write enable.
- `vi`  out  8  mb8 write data to memory.
- `vo`  in  8  mb8 read data from memory; registered in memory, valid the cycle after `ai` is presented.

## Operation

- FSM states: IDLE, RD, WR, DONE. `rdy` = (state == IDLE).
- IDLE: on `req & rdy` latch `wr`, `waddr`, `wdata`, `be`; beat counter ← 0; go RD or WR.
- WR: four beats, n = 0..3. Beat n drives `ai = {waddr, n}`, `vi = wdata[8n+7:8n]`, `we = be[n]`. After beat 3 → DONE.
- RD: drives `ai = {waddr, n}` for n = 0..3 with `we = 0`; captures `vo` into `rdata[8n+7:8n]` one cycle after byte n's address. A fifth RD cycle (address don't-care, held at last value, `we=0`) captures byte 3. Then → DONE.
- DONE: `done = 1` for exactly one cycle, `we = 0`; → IDLE.
- `req` while not `rdy`: ignored, no queueing; initiator must hold `req` until accepted.
- `be = 4'b0000` write: four beats run, `we` never asserts, `done` still pulses.
- No address wrap possible: max word 0x7FFF → bytes 0x1FFFC–0x1FFFF.
- `rdata` updates only on reads; a write leaves it unchanged.

## Timing

- Reset values: state IDLE, `rdy=1`, `done=0`, `we=0`, `ai=0`, `vi=0`, `rdata=0`, beat counter 0.
- Reset mid-operation: immediate abort to IDLE; no `done`; partial writes already issued remain in memory.
- Accept edge = E0. Outputs (`ai`, `we`, `vi`) are registered.
- Write: beats visible in cycles after E0..E3; `done` in cycle after E4; `rdy` high after E5. Latency 5 cycles accept→done.
- Read: addresses in cycles after E0..E3; bytes captured at E2..E5; `done` and full `rdata` in cycle after E5; `rdy` after E6. Latency 6 cycles.
- Back-to-back: with `req` held high, next accept occurs on the first edge with `rdy=1` (one cycle after `done`). Throughput: one write per 6 cycles, one read per 7.

## Test plan

- Reset check: assert `rst` asynchronously mid-cycle → `rdy=1`, `we=0`, `done=0`, `ai=0`, `rdata=0` without waiting for `clk`.
- Write then read: write `waddr=0x0010`, `wdata=0xDEADBEEF`, `be=4'hF` → memory bytes 0x40..0x43 = EF,BE,AD,DE; `done` 5 cycles after accept. Read same → `rdata=0xDEADBEEF` with `done` 6 cycles after accept.
- Partial write: over 0xDEADBEEF write `0x11223344` with `be=4'b0101` → readback `0xDE22BE44`; `we` high only in beats 0 and 2.
- Top address: write/read `waddr=0x7FFF`, data `0xA5C3_0F1E` → `ai` spans 0x1FFFC–0x1FFFF, readback matches.
- Busy and back-to-back: pulse extra `req` during a read → ignored; hold `req` for read/write/read sequence → accepts exactly one cycle after each `done`, `rdata` unchanged by the write.
- Reset mid-write: assert `rst` after beat 1 of a `0xFFFFFFFF` write over zeroed word → readback `0x0000FFFF`, no `done` for aborted op.
